fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: exec  input  1  start/stop button level; rising edge is the command.
REQ-005 Port: imem_addr  output  16  instruction-memory address; always equals pc_out.
REQ-006 Port: imem_q  input  16  instruction-memory data; valid 1 cycle after address is presented.
REQ-007 Port: instr  output  16  fetched instruction word to the execute core.
REQ-008 Port: instr_valid  output  1  instr holds a fetched, unconsumed instruction.
REQ-009 Port: instr_ready  input  1  core retires the current instruction; handshake = instr_valid & instr_ready.
REQ-010 Port: j_flag  input  1  taken branch/jump for the retiring instruction.
REQ-011 Port: j_addr  input  16  branch/jump target.
REQ-012 Port: halt  input  1  retiring instruction is HLT.
REQ-013 Port: pc_out  output  16  current PC.
REQ-014 Port: pc_inc  output  16  pc_out + 1, modulo 2^16, combinational.
REQ-015 Port: running  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, FETCH, LATCH, HOLD.
REQ-017 IDLE: instr_valid=0; on exec rising edge -> FETCH, stop_pending cleared.
REQ-018 FETCH: imem_addr=pc presented; next cycle -> LATCH unconditionally.
REQ-019 LATCH: instr <= imem_q, instr_valid <= 1, -> HOLD; fetch latency address-to-valid = 2 cycles.
REQ-020 HOLD: instr and instr_valid held stable until handshake; no PC change without handshake.
REQ-021 On handshake: pc <= j_flag ? j_addr : pc+1; instr_valid <= 0; j_flag, j_addr and halt are ignored outside the handshake cycle.
REQ-022 After handshake: -> IDLE if halt, stop_pending, or an exec edge in that same cycle; otherwise -> FETCH.
REQ-023 Exec edge while running and not in a handshake cycle sets stop_pending; the current instruction always completes, never aborts.
REQ-024 PC increment wraps 16'hFFFF -> 16'h0000; jump to any 16-bit target is legal, including the current PC.
REQ-025 instr retains its last value in IDLE; PC retains the post-retire value across stop/restart (resume, not restart from RESET_PC).
REQ-026 Exec held high produces exactly one command; a new command requires a low-to-high transition.

Reset
REQ-027 rst in any state, including mid-fetch: state=IDLE, pc=RESET_PC, instr=16'h0000, instr_valid=0, running=0, stop_pending=0, edge-detector history=0, effective next edge.
REQ-028 rst has priority over exec, instr_ready and all other inputs in the same cycle.

Structure
REQ-029 Shared package simple_pkg holds WORD_W=16, RESET_PC default, and the fetch-state encoding constants.
REQ-030 One sub-module, edge_detect: registered rising-edge detector on exec, synchronously reset by rst.
REQ-031 Fetch state, PC, instr and stop_pending are registers in fetch_unit; pc_inc and imem_addr are combinational.

Verification
REQ-032 Reset, exec pulse, memory word 0 = 16'h1234, ready held high -> instr=16'h1234, instr_valid high 2 cycles after FETCH entry, pc_out=1 after handshake.
REQ-033 Handshake with j_flag=1, j_addr=16'h0040 -> next imem_addr=16'h0040; j_flag=1 outside handshake -> no PC change.
REQ-034 PC=16'hFFFF, retire without jump -> pc_out=16'h0000, pc_inc=16'h0001.
REQ-035 Exec edge while in HOLD with ready low -> instruction retires when ready rises, then IDLE, running=0, pc_out=old PC+1; next exec edge resumes at that PC.
REQ-036 halt=1 at handshake -> IDLE; exec held high for 10 cycles in IDLE -> exactly one restart.
REQ-037 rst asserted in LATCH -> next cycle IDLE, pc_out=RESET_PC, instr_valid=0, instr=16'h0000.

Source files
------------

// File: rtl/simple_pkg.sv
// Shared definitions for the instruction fetch unit: word width,
// default reset PC and the fetch-state encoding.
package simple_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LATCH = 2'd2,
      ST_HOLD  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector on a level input. The history flop is cleared by
// reset, so an input already high after reset counts as a fresh edge.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   // Next history value is simply the current input level
   always_comb begin
      prev_d = sig_in;
   end

   // History register, cleared on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks IDLE -> FETCH -> LATCH -> HOLD, presents
// the PC to a 1-cycle-latency instruction memory, holds the fetched word
// until the core retires it, and handles start/stop commands from exec.
module fetch_unit
   import simple_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exec,
   output logic [WORD_W-1:0] imem_addr,
   input  logic [WORD_W-1:0] imem_q,
   output logic [WORD_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              j_flag,
   input  logic [WORD_W-1:0] j_addr,
   input  logic              halt,
   output logic [WORD_W-1:0] pc_out,
   output logic [WORD_W-1:0] pc_inc,
   output logic              running
);

   fetch_state_e      state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              stop_q, stop_d;
   logic              exec_rise;
   logic              handshake;

   edge_detect u_exec_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_in (exec),
      .rise   (exec_rise)
   );

   assign handshake = valid_q & instr_ready;
   assign pc_inc    = pc_q + 16'd1;

   // Next-state, PC, instruction and stop-request logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      stop_d  = stop_q;
      case (state_q)
         ST_IDLE: begin
            if (exec_rise) begin
               state_d = ST_FETCH;
               stop_d  = 1'b0;
            end
         end
         ST_FETCH: begin
            // Address is on imem_addr this cycle; data arrives next cycle
            state_d = ST_LATCH;
            if (exec_rise) stop_d = 1'b1;
         end
         ST_LATCH: begin
            instr_d = imem_q;
            valid_d = 1'b1;
            state_d = ST_HOLD;
            if (exec_rise) stop_d = 1'b1;
         end
         ST_HOLD: begin
            if (handshake) begin
               pc_d    = j_flag ? j_addr : pc_inc;
               valid_d = 1'b0;
               if (halt || stop_q || exec_rise) begin
                  state_d = ST_IDLE;
                  stop_d  = 1'b0;
               end else begin
                  state_d = ST_FETCH;
               end
            end else if (exec_rise) begin
               // Stop is deferred: the held instruction still retires
               stop_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset taking priority over all inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         stop_q  <= stop_d;
      end
   end

   assign imem_addr   = pc_q;
   assign pc_out      = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign running     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural reference model with a
// per-cycle comparator, plus directed scenarios with literal expectations.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        exec = 1'b0;
   logic        instr_ready = 1'b0;
   logic        j_flag = 1'b0;
   logic        halt = 1'b0;
   logic [15:0] j_addr = 16'h0000;
   logic [15:0] imem_addr, imem_q, instr, pc_out, pc_inc;
   logic        instr_valid, running;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .exec        (exec),
      .imem_addr   (imem_addr),
      .imem_q      (imem_q),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .j_flag      (j_flag),
      .j_addr      (j_addr),
      .halt        (halt),
      .pc_out      (pc_out),
      .pc_inc      (pc_inc),
      .running     (running)
   );

   // Instruction memory with one cycle of read latency
   logic [15:0] mem [0:65535];
   always @(posedge clk) imem_q <= mem[imem_addr];

   int checks = 0;
   int passes = 0;

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // m_age counts cycles since the fetch started: 0 = address out,
   // 1 = memory data returning, 2 = word held for the core.
   logic [15:0] m_pc, m_instr;
   bit          m_valid, m_running, m_stop, m_prev, m_rose;
   int          m_age;
   bit          model_ok = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 0; m_running = 0;
         m_stop = 0; m_prev = 0; m_age = 0; model_ok = 1;
      end else begin
         m_rose = exec && !m_prev;
         m_prev = exec;
         if (!m_running) begin
            if (m_rose) begin
               m_running = 1; m_age = 0; m_stop = 0;
            end
         end else if (m_age == 0) begin
            m_age = 1;
            if (m_rose) m_stop = 1;
         end else if (m_age == 1) begin
            m_instr = mem[m_pc]; m_valid = 1; m_age = 2;
            if (m_rose) m_stop = 1;
         end else if (instr_ready) begin
            m_pc = j_flag ? j_addr : m_pc + 16'd1;
            m_valid = 0;
            if (halt || m_stop || m_rose) m_running = 0;
            else m_age = 0;
         end else if (m_rose) begin
            m_stop = 1;
         end
      end
   end

   // Compare process: every cycle once the model has seen a reset
   always @(negedge clk) begin
      if (model_ok) begin
         check16("pc_out", pc_out, m_pc);
         check16("imem_addr", imem_addr, m_pc);
         check16("pc_inc", pc_inc, m_pc + 16'd1);
         check16("instr", instr, m_instr);
         check16("instr_valid", {15'd0, instr_valid}, {15'd0, m_valid});
         check16("running", {15'd0, running}, {15'd0, m_running});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!instr_valid && n < 12) begin
         step();
         n++;
      end
      if (!instr_valid) begin
         checks++;
         $display("FAIL wait_valid: got instr_valid=0 required 1 within 12 cycles");
      end
   endtask

   int  rises;
   bit  prev_run;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
      mem[0]        = 16'h1234;
      mem[16'hFFFF] = 16'hBEEF;

      // Reset state
      step(); step();
      rst = 0;
      check16("rst_pc", pc_out, 16'h0000);
      check16("rst_valid", {15'd0, instr_valid}, 16'd0);
      check16("rst_running", {15'd0, running}, 16'd0);
      check16("rst_instr", instr, 16'h0000);

      // First fetch: valid two cycles after FETCH entry, pc=1 after retire
      exec = 1; step(); exec = 0;
      check16("a_running", {15'd0, running}, 16'd1);
      check16("a_addr", imem_addr, 16'h0000);
      instr_ready = 1;
      step();
      check16("a_latch_valid", {15'd0, instr_valid}, 16'd0);
      step();
      check16("a_hold_valid", {15'd0, instr_valid}, 16'd1);
      check16("a_instr", instr, 16'h1234);
      step();
      check16("a_pc_after", pc_out, 16'h0001);
      check16("a_valid_after", {15'd0, instr_valid}, 16'd0);

      // Jump: asserted early (ignored) then taken at the handshake
      j_flag = 1; j_addr = 16'h0040;
      step();
      check16("j_latch_pc", pc_out, 16'h0001);
      step();
      check16("j_hold_pc", pc_out, 16'h0001);
      step();
      check16("j_target", imem_addr, 16'h0040);
      j_flag = 0; j_addr = 16'h0000;

      // Wrap: jump to FFFF then retire without jump
      wait_valid();
      j_flag = 1; j_addr = 16'hFFFF;
      step();
      j_flag = 0; j_addr = 16'h0000;
      check16("w_pc_ffff", pc_out, 16'hFFFF);
      wait_valid();
      step();
      check16("w_pc_wrap", pc_out, 16'h0000);
      check16("w_pc_inc", pc_inc, 16'h0001);
      check16("w_instr", instr, 16'hBEEF);

      // Stop request while holding: instruction completes, then IDLE, then resume
      instr_ready = 0;
      wait_valid();
      check16("s_instr", instr, 16'h1234);
      exec = 1; step(); exec = 0;
      step(); step();
      check16("s_hold_valid", {15'd0, instr_valid}, 16'd1);
      check16("s_hold_pc", pc_out, 16'h0000);
      instr_ready = 1; step(); instr_ready = 0;
      check16("s_idle_running", {15'd0, running}, 16'd0);
      check16("s_idle_pc", pc_out, 16'h0001);
      step(); step();
      check16("s_still_idle", {15'd0, running}, 16'd0);
      exec = 1; step(); exec = 0;
      check16("s_resume_running", {15'd0, running}, 16'd1);
      check16("s_resume_addr", imem_addr, 16'h0001);

      // Halt, then exec held high for 10 cycles: exactly one restart
      wait_valid();
      halt = 1; instr_ready = 1; step(); halt = 0;
      check16("h_running", {15'd0, running}, 16'd0);
      check16("h_pc", pc_out, 16'h0002);
      exec = 1; rises = 0; prev_run = running;
      for (int i = 0; i < 10; i++) begin
         step();
         if (running && !prev_run) rises++;
         prev_run = running;
      end
      exec = 0;
      check16("h_restarts", 16'(rises), 16'd1);
      check16("h_still_run", {15'd0, running}, 16'd1);
      wait_valid();
      halt = 1; step(); halt = 0;

      // Reset during LATCH
      exec = 1; step(); exec = 0;
      step();
      rst = 1; step(); rst = 0;
      check16("r_running", {15'd0, running}, 16'd0);
      check16("r_pc", pc_out, 16'h0000);
      check16("r_valid", {15'd0, instr_valid}, 16'd0);
      check16("r_instr", instr, 16'h0000);

      // exec high through reset counts as a fresh edge afterwards
      exec = 1; rst = 1; step();
      check16("r_prio", {15'd0, running}, 16'd0);
      rst = 0; step();
      check16("r_edge_after", {15'd0, running}, 16'd1);
      exec = 0;

      // Mixed traffic, checked cycle by cycle against the model
      for (int i = 0; i < 400; i++) begin
         rst         = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 5) == 0) exec = ~exec;
         instr_ready = $urandom_range(0, 2) != 0;
         j_flag      = $urandom_range(0, 3) == 0;
         j_addr      = 16'($urandom);
         halt        = $urandom_range(0, 9) == 0;
         step();
      end
      rst = 0; exec = 0; instr_ready = 0; j_flag = 0; halt = 0;
      step(); step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
